// File: rtl/sprite_blitter_if.sv
// Control and plot-bus bundle between a game-object FSM (master) and sprite_blitter (slave).
interface sprite_blitter_if #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 12
);
    logic               start;
    logic [X_W-1:0]     x_init;
    logic [Y_W-1:0]     y_init;
    logic               busy;
    logic               done;
    logic [X_W-1:0]     x_out;
    logic [Y_W-1:0]     y_out;
    logic [COLOR_W-1:0] color_out;
    logic               plot;

    modport master (
        output start, x_init, y_init,
        input  busy, done, x_out, y_out, color_out, plot
    );

    modport slave (
        input  start, x_init, y_init,
        output busy, done, x_out, y_out, color_out, plot
    );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks an SPR_W x SPR_H ROM in raster order and emits clipped, ROM-latency-aligned plots.
// Define SPRITE_BLITTER_TRANSPARENT_EN to suppress plots of pixels whose colour equals TRANSP_KEY.
module sprite_blitter #(
    parameter int                  SPR_W      = 16,
    parameter int                  SPR_H      = 16,
    parameter int                  ADDR_W     = 8,
    parameter int                  X_W        = 9,
    parameter int                  Y_W        = 8,
    parameter int                  COLOR_W    = 12,
    parameter int                  SCREEN_W   = 320,
    parameter int                  SCREEN_H   = 240,
    parameter int                  ROM_LAT    = 1,
    parameter logic [COLOR_W-1:0]  TRANSP_KEY = '0
) (
    input  logic               clk,
    input  logic               resetn,
    sprite_blitter_if.slave    bus,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_q,
    input  logic               clr_count,
    output logic [7:0]         sprite_count
);
    localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int FL_W  = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FLUSH, S_DONE} state_t;

    state_t             state;
    logic [X_W-1:0]     x0;
    logic [Y_W-1:0]     y0;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [FL_W-1:0]    flush_cnt;
    logic               busy_r;
    logic               done_r;
    logic               last_col;
    logic               last_pix;

    logic               vld_p0 [ROM_LAT];
    logic [COL_W-1:0]   col_p0 [ROM_LAT];
    logic [ROW_W-1:0]   row_p0 [ROM_LAT];

    logic [X_W-1:0]     x_p1;
    logic [Y_W-1:0]     y_p1;
    logic [COLOR_W-1:0] color_p1;
    logic               vld_p1;

    logic [X_W:0]       x_sum;
    logic [Y_W:0]       y_sum;
    logic               keep;

    function automatic logic on_screen(input logic [X_W:0] xs, input logic [Y_W:0] ys);
        return (xs < (X_W+1)'(SCREEN_W)) && (ys < (Y_W+1)'(SCREEN_H));
    endfunction

    assign last_col = (col == COL_W'(SPR_W - 1));
    assign last_pix = last_col && (row == ROW_W'(SPR_H - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= S_IDLE;
            col          <= '0;
            row          <= '0;
            rom_addr     <= '0;
            flush_cnt    <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            sprite_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state    <= S_DRAW;
                        busy_r   <= 1'b1;
                        col      <= '0;
                        row      <= '0;
                        rom_addr <= '0;
                    end
                end
                S_DRAW: begin
                    if (last_pix) begin
                        state     <= S_FLUSH;
                        col       <= '0;
                        row       <= '0;
                        rom_addr  <= '0;
                        flush_cnt <= '0;
                    end else begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        if (last_col) begin
                            col <= '0;
                            row <= row + ROW_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    // Hold long enough for the final pixel to clear the ROM and output stages.
                    if (flush_cnt == FL_W'(ROM_LAT)) begin
                        state  <= S_DONE;
                        done_r <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FL_W'(1);
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase

            if (clr_count)
                sprite_count <= '0;
            else if (state == S_DONE)
                sprite_count <= sprite_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.start) begin
            x0 <= bus.x_init;
            y0 <= bus.y_init;
        end
    end

    // ---- p0: col/row delay line matching ROM read latency ----
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < ROM_LAT; i++) vld_p0[i] <= 1'b0;
        end else begin
            vld_p0[0] <= (state == S_DRAW);
            for (int i = 1; i < ROM_LAT; i++) vld_p0[i] <= vld_p0[i-1];
        end
    end

    always_ff @(posedge clk) begin
        col_p0[0] <= col;
        row_p0[0] <= row;
        for (int i = 1; i < ROM_LAT; i++) begin
            col_p0[i] <= col_p0[i-1];
            row_p0[i] <= row_p0[i-1];
        end
    end

    assign x_sum = {1'b0, x0} + (X_W+1)'(col_p0[ROM_LAT-1]);
    assign y_sum = {1'b0, y0} + (Y_W+1)'(row_p0[ROM_LAT-1]);

`ifdef SPRITE_BLITTER_TRANSPARENT_EN
    assign keep = (rom_q != TRANSP_KEY);
`else
    logic unused_key;
    assign keep       = 1'b1;
    assign unused_key = ^TRANSP_KEY;
`endif

    // ---- p1: registered plot outputs ----
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p1   <= 1'b0;
            x_p1     <= '0;
            y_p1     <= '0;
            color_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0[ROM_LAT-1] && on_screen(x_sum, y_sum) && keep;
            if (vld_p0[ROM_LAT-1]) begin
                x_p1     <= x_sum[X_W-1:0];
                y_p1     <= y_sum[Y_W-1:0];
                color_p1 <= rom_q;
            end
        end
    end

    assign bus.x_out     = x_p1;
    assign bus.y_out     = y_p1;
    assign bus.color_out = color_p1;
    assign bus.plot      = vld_p1;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a default 16x16/latency-1 instance and a 5x3/latency-2 instance.
module tb_sprite_blitter;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       clr_count = 1'b0;
    logic       sel = 1'b0;
    logic [8:0] x_init = '0;
    logic [7:0] y_init = '0;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt [2];
    int first_x, first_y, last_x, last_y;

`ifdef SPRITE_BLITTER_TRANSPARENT_EN
    localparam int FULL_A = 128, CLIP_A = 16, FULL_B = 8, LAST_X = 24;
`else
    localparam int FULL_A = 256, CLIP_A = 32, FULL_B = 15, LAST_X = 25;
`endif

    always #5 clk = ~clk;

    sprite_blitter_if #(.X_W(9), .Y_W(8), .COLOR_W(12)) if_a ();
    sprite_blitter_if #(.X_W(9), .Y_W(8), .COLOR_W(12)) if_b ();

    logic [7:0]  rom_addr_a, rom_addr_b, cnt_a, cnt_b;
    logic [11:0] rom_q_a, rom_b_p0, rom_q_b;
    logic        clr_a, clr_b;

    assign if_a.start  = start & ~sel;
    assign if_b.start  = start & sel;
    assign if_a.x_init = x_init;
    assign if_b.x_init = x_init;
    assign if_a.y_init = y_init;
    assign if_b.y_init = y_init;
    assign clr_a = clr_count & ~sel;
    assign clr_b = clr_count & sel;

    function automatic logic [11:0] rom_color(input int k);
        if (k % 2 != 0) return 12'h000;
        return 12'h100 + k[11:0];
    endfunction

    always_ff @(posedge clk) rom_q_a <= rom_color(int'(rom_addr_a));
    always_ff @(posedge clk) begin
        rom_b_p0 <= rom_color(int'(rom_addr_b));
        rom_q_b  <= rom_b_p0;
    end

    sprite_blitter dut_a (
        .clk(clk), .resetn(resetn), .bus(if_a),
        .rom_addr(rom_addr_a), .rom_q(rom_q_a),
        .clr_count(clr_a), .sprite_count(cnt_a)
    );

    sprite_blitter #(.SPR_W(5), .SPR_H(3), .ROM_LAT(2)) dut_b (
        .clk(clk), .resetn(resetn), .bus(if_b),
        .rom_addr(rom_addr_b), .rom_q(rom_q_b),
        .clr_count(clr_b), .sprite_count(cnt_b)
    );

    logic        m_plot, m_busy, m_done;
    logic [8:0]  m_x;
    logic [7:0]  m_y, m_addr, m_cnt;
    logic [11:0] m_color;
    assign m_plot  = sel ? if_b.plot      : if_a.plot;
    assign m_busy  = sel ? if_b.busy      : if_a.busy;
    assign m_done  = sel ? if_b.done      : if_a.done;
    assign m_x     = sel ? if_b.x_out     : if_a.x_out;
    assign m_y     = sel ? if_b.y_out     : if_a.y_out;
    assign m_color = sel ? if_b.color_out : if_a.color_out;
    assign m_addr  = sel ? rom_addr_b     : rom_addr_a;
    assign m_cnt   = sel ? cnt_b          : cnt_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_plot"},  m_plot, 0);
        check({tag, "_busy"},  m_busy, 0);
        check({tag, "_done"},  m_done, 0);
        check({tag, "_x"},     m_x, 0);
        check({tag, "_y"},     m_y, 0);
        check({tag, "_color"}, m_color, 0);
        check({tag, "_addr"},  m_addr, 0);
        check({tag, "_count"}, m_cnt, 0);
    endtask

    // One full draw; b selects the instance, poke pulses start during DRAW and FLUSH.
    task automatic draw(input bit b, input logic [8:0] xi, input logic [7:0] yi,
                        input int exp_plots, input bit poke, input bit clr);
        int w, n_pix, lat, plots, done_rel, k, extra;
        sel   = b;
        w     = b ? 5 : 16;
        n_pix = b ? 15 : 256;
        lat   = b ? 2 : 1;
        plots = 0;
        done_rel = -1;
        @(negedge clk);
        x_init = xi; y_init = yi; start = 1'b1;
        @(negedge clk);
        start = 1'b0; x_init = xi + 9'd7; y_init = yi + 8'd3;
        for (int rel = 1; rel <= n_pix + lat + 20; rel++) begin
            check("busy", m_busy, 1);
            if (rel <= n_pix) check("rom_addr", m_addr, rel - 1);
            if (m_plot) begin
                k = (int'(m_y) - int'(yi)) * w + (int'(m_x) - int'(xi));
                check("plot_time", rel, 2 + lat + k);
                check("color", m_color, rom_color(k));
                if (plots == 0) begin first_x = int'(m_x); first_y = int'(m_y); end
                last_x = int'(m_x); last_y = int'(m_y);
                plots++;
            end
            start = poke && (rel == 40 || rel == n_pix + 1);
            clr_count = clr && m_done;
            if (m_done) begin
                done_rel = rel;
                break;
            end
            @(negedge clk);
        end
        check("plots", plots, exp_plots);
        check("done_time", done_rel, n_pix + lat + 2);
        @(negedge clk);
        start = 1'b0; clr_count = 1'b0;
        exp_cnt[b] = clr ? 0 : (exp_cnt[b] + 1) % 256;
        check("sprite_count", m_cnt, exp_cnt[b]);
        check("busy_after", m_busy, 0);
        extra = 0;
        repeat (10) begin
            if (m_done || m_plot || m_busy) extra++;
            @(negedge clk);
        end
        check("idle_quiet", extra, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int strays;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        draw(0, 9'd10, 8'd20, FULL_A, 0, 0);
        check("first_x", first_x, 10);
        check("first_y", first_y, 20);
        check("last_x", last_x, LAST_X);
        check("last_y", last_y, 35);

        draw(0, 9'd30, 8'd40, FULL_A, 1, 0);
        draw(0, 9'd312, 8'd236, CLIP_A, 0, 0);

        // Reset while rom_addr is at pixel 100.
        sel = 1'b0;
        @(negedge clk);
        x_init = 9'd50; y_init = 8'd60; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_addr", m_addr, 100);
        resetn = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        resetn = 1'b1;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        strays = 0;
        repeat (10) begin
            if (m_plot || m_busy) strays++;
            @(negedge clk);
        end
        check("stray_plot", strays, 0);
        draw(0, 9'd50, 8'd60, FULL_A, 0, 0);

        draw(1, 9'd100, 8'd50, FULL_B, 0, 0);
        draw(0, 9'd10, 8'd20, FULL_A, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised sprite drawing engine: on a `start` pulse it walks an `SPR_W` x `SPR_H` sprite ROM in raster order and emits one plot request per pixel at screen position (`x_init`+col, `y_init`+row). It generalises the fixed 16x16 gold/stone drawers with:

- configurable sprite size, coordinate widths and ROM latency;
- a start/busy/done handshake and latency-aligned plot valid;
- screen-edge clipping;
- optional colour-key transparency.

It sits between the game-object FSMs and the VGA plot multiplexer.

## Interface
Parameters:
- `SPR_W`, 16, sprite width in pixels (≥1)
- `SPR_H`, 16, sprite height in pixels (≥1)
- `ADDR_W`, 8, ROM address width; `SPR_W*SPR_H` ≤ 2^`ADDR_W`
- `X_W`, 9, screen x width
- `Y_W`, 8, screen y width
- `COLOR_W`, 12, colour width
- `SCREEN_W`, 320, visible width
- `SCREEN_H`, 240, visible height
- `ROM_LAT`, 1, cycles from `rom_addr` presented to `rom_q` valid (≥1)
- `TRANSP_KEY`, 12'h000, transparent colour (used only with the macro below)

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset; synchronous, active-low
- `start`  in  1  draw request; sampled only in IDLE
- `x_init`  in  `X_W`  sprite top-left x
- `y_init`  in  `Y_W`  sprite top-left y
- `rom_addr`  out  `ADDR_W`  sprite ROM address
- `rom_q`  in  `COLOR_W`  sprite ROM data
- `x_out`  out  `X_W`  plot x
- `y_out`  out  `Y_W`  plot y
- `color_out`  out  `COLOR_W`  plot colour
- `plot`  out  1  `x_out`/`y_out`/`color_out` valid this cycle
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle completion pulse
- `clr_count`  in  1  synchronous clear of `sprite_count`
- `sprite_count`  out  8  completed-sprite counter, wraps 255→0

## Operation
States and transitions:
- **IDLE**
  - `start`=1: latch `x_init`/`y_init`, zero the col/row/address counters, go to DRAW.
- **DRAW**
  - Each cycle: present the address counter on `rom_addr` and push (col, row, valid=1) into a `ROM_LAT`-deep pipeline.
  - Increment col. When col wraps from `SPR_W`-1 to 0, increment row.
  - The address counter increments by 1; no multiplier.
  - After pixel N-1 (N=`SPR_W*SPR_H`) is issued, go to FLUSH.
- **FLUSH**
  - Lasts `ROM_LAT`+1 cycles and pushes valid=0.
  - Then go to DONE.
- **DONE**
  - `done`=1 for one cycle and `sprite_count` increments.
  - Go to IDLE.

Other rules:
- `start` is ignored while `busy`. The latched origin does not change mid-draw.
- Output stage, registered:
  - `x_out` = x0 + col and `y_out` = y0 + row.
  - Sums are computed at `X_W`+1 / `Y_W`+1 bits.
  - `plot` = pipeline valid AND x_sum < `SCREEN_W` AND y_sum < `SCREEN_H`.
  - `x_out`/`y_out`/`color_out` update on every pipeline-valid cycle, clipped or not.
- `clr_count` has priority over the DONE increment in the same cycle.
- Reset (`resetn`=0 at a clk edge, including mid-draw):
  - state → IDLE; all counters, pipeline valids, `plot`, `busy`, `done` → 0;
  - `x_out`, `y_out`, `color_out`, `rom_addr`, `sprite_count` → 0.
  - No pending pixel emerges after reset.

## Timing
- `start` is sampled high in IDLE at edge T. DRAW then occupies cycles T+1..T+N, and `rom_addr`=k in cycle T+1+k.
- Pixel k: `plot` is in cycle T+2+`ROM_LAT`+k. Plots are contiguous with no bubbles unless clipped.
- Last plot is in cycle T+N+`ROM_LAT`+1 (final FLUSH cycle).
- `done` is in cycle T+N+`ROM_LAT`+2.
- `busy` is high from T+1 through the `done` cycle.
- Earliest next accepted `start` is in the cycle after `done`.
- Total draw time: N+`ROM_LAT`+2 cycles, start-to-done exclusive of T.

## Configuration
`SPRITE_BLITTER_TRANSPARENT_EN`:
- Defined: `plot` is additionally gated by `rom_q` ≠ `TRANSP_KEY`. Transparent pixels still occupy their cycle; timing and `done` are unchanged.
- Undefined: every in-screen pixel plots, and `TRANSP_KEY` is unused.

## Test plan
- **Default params, ROM_LAT=1.** Stimulus: x_init=10, y_init=20, start at T. Required:
  - 256 plots in cycles T+3..T+258;
  - first (10,20), last (25,35), colours equal ROM[k];
  - `done` at T+259 and `sprite_count`=1.
- **Clipping.** Stimulus: x_init=312, y_init=236. Required:
  - only col 0–7 / row 0–3 plot (32 plots);
  - `done` timing unchanged.
- **start while busy.** Stimulus: pulse `start` during DRAW and during FLUSH. Required:
  - no restart, origin unchanged;
  - exactly one `done`.
- **Reset mid-draw.** Stimulus: `resetn`=0 at pixel 100. Required:
  - next cycle all outputs 0 and `plot`=0 with no stray plot;
  - a new start draws the full sprite.
- **Parameter sweep.** Stimulus: SPR_W=5, SPR_H=3, ROM_LAT=2. Required:
  - addresses 0..14, row wrap after col 4;
  - `done` at T+19.
- **Transparency and counter clear** (macro defined). Stimulus: ROM half `TRANSP_KEY`, plus `clr_count` asserted in the `done` cycle. Required:
  - 128 plots;
  - `sprite_count` reads 0 after the `done` cycle.
